regfile_sb: RTL and testbench

Parametrised integer register file for the RISC-V core, with two combinational read ports and one synchronous write port. It adds three behaviours: a hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection. After reset, a sequential clear sweep zeroes the array, and `ready` signals when the sweep is done. It sits between decode (reads, scoreboard set) and writeback (WE3/A3/WD3).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sb_if.sv | 33 +++
 rtl/reg_scoreboard.sv | 39 +++
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file and its scoreboard.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback side bundle of the register file: read ports, write port, scoreboard set.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  localparam int unsigned AW  = $clog2(NREG)
) ();

  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic [AW-1:0]   A3;
  logic            WE3;
  logic [XLEN-1:0] WD3;
  logic            sb_set;
  logic [AW-1:0]   sb_addr;
  logic            busy1;
  logic            busy2;
  logic            ready;

  modport master (
    output A1, A2, A3, WE3, WD3, sb_set, sb_addr,
    input  RD1, RD2, busy1, busy2, ready
  );

  modport slave (
    input  A1, A2, A3, WE3, WD3, sb_set, sb_addr,
    output RD1, RD2, busy1, busy2, ready
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue of a long-latency producer, cleared on writeback.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic [AW-1:0] set_addr,
  input  logic          clr,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          busy1_c,
  output logic          busy2_c
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (clr && (clr_addr != AW'(ZERO_REG))) busy_d[clr_addr] = 1'b0;
    if (set && (set_addr != AW'(ZERO_REG))) busy_d[set_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy1_c = busy_q[q1_addr];
  assign busy2_c = busy_q[q2_addr];

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: zero register, optional write bypass, busy scoreboard,
// and a post-reset clear sweep that gates all outputs until the array is zeroed.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] regs_q [NREG];

  logic            run_c;
  logic            wr_en_c;
  logic [AW-1:0]   wr_addr_c;
  logic [XLEN-1:0] wr_data_c;
  logic [XLEN-1:0] rd1_c, rd2_c;
  logic            byp1_c, byp2_c;
  logic            mask1_c, mask2_c;
  logic            sb_busy1_c, sb_busy2_c;

  assign run_c = (state_q == RUN);

  // Sweep/run control; the sweep owns the array write port until it finishes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_c   = 1'b0;
    wr_addr_c = bus.A3;
    wr_data_c = bus.WD3;
    case (state_q)
      INIT: begin
        wr_en_c   = 1'b1;
        wr_addr_c = cnt_q;
        wr_data_c = '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        wr_en_c = bus.WE3 && (bus.A3 != AW'(ZERO_REG));
      end
      default: state_d = INIT;
    endcase
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage array is deliberately not reset; the sweep clears it.
  always_ff @(posedge clk) begin
    if (wr_en_c) regs_q[wr_addr_c] <= wr_data_c;
  end

  assign byp1_c  = BYPASS && bus.WE3 && (bus.A3 == bus.A1);
  assign byp2_c  = BYPASS && bus.WE3 && (bus.A3 == bus.A2);
  assign mask1_c = byp1_c && !(bus.sb_set && (bus.sb_addr == bus.A1));
  assign mask2_c = byp2_c && !(bus.sb_set && (bus.sb_addr == bus.A2));

  always_comb begin
    rd1_c = '0;
    if (run_c && (bus.A1 != AW'(ZERO_REG))) rd1_c = byp1_c ? bus.WD3 : regs_q[bus.A1];
  end

  always_comb begin
    rd2_c = '0;
    if (run_c && (bus.A2 != AW'(ZERO_REG))) rd2_c = byp2_c ? bus.WD3 : regs_q[bus.A2];
  end

  reg_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set      (run_c && bus.sb_set),
    .set_addr (bus.sb_addr),
    .clr      (run_c && bus.WE3),
    .clr_addr (bus.A3),
    .q1_addr  (bus.A1),
    .q2_addr  (bus.A2),
    .busy1_c  (sb_busy1_c),
    .busy2_c  (sb_busy2_c)
  );

  assign bus.RD1   = rd1_c;
  assign bus.RD2   = rd2_c;
  assign bus.busy1 = run_c && sb_busy1_c && !mask1_c;
  assign bus.busy2 = run_c && sb_busy2_c && !mask2_c;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with bypass, one without, same stimulus.
module tb_regfile_sb;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  regfile_sb_if #(.XLEN(32), .NREG(32)) bus_b ();
  regfile_sb_if #(.XLEN(32), .NREG(32)) bus_n ();

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n.slave)
  );

  assign bus_n.A1      = bus_b.A1;
  assign bus_n.A2      = bus_b.A2;
  assign bus_n.A3      = bus_b.A3;
  assign bus_n.WE3     = bus_b.WE3;
  assign bus_n.WD3     = bus_b.WD3;
  assign bus_n.sb_set  = bus_b.sb_set;
  assign bus_n.sb_addr = bus_b.sb_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b0;
    bus_b.A1 = '0; bus_b.A2 = '0; bus_b.A3 = '0;
    bus_b.WE3 = 1'b0; bus_b.WD3 = '0;
    bus_b.sb_set = 1'b0; bus_b.sb_addr = '0;
    #2;
    chk("rst_ready", 32'(bus_b.ready), 32'd0);
    chk("rst_rd1",   bus_b.RD1,        32'd0);
    chk("rst_busy1", 32'(bus_b.busy1), 32'd0);

    // Writes attempted throughout the sweep must be dropped.
    bus_b.WE3 = 1'b1; bus_b.A3 = 5'd5; bus_b.WD3 = 32'h0000_DEAD; bus_b.A1 = 5'd5;
    #10 rst = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("sweep_ready", 32'(bus_b.ready), (k == 32) ? 32'd1 : 32'd0);
      if (k == 16) chk("sweep_rd1", bus_b.RD1, 32'd0);
    end
    bus_b.WE3 = 1'b0;
    #1;
    chk("sweep_x5_b", bus_b.RD1, 32'd0);
    chk("sweep_x5_n", bus_n.RD1, 32'd0);

    // Plain write then read.
    bus_b.WE3 = 1'b1; bus_b.A3 = 5'd7; bus_b.WD3 = 32'h1234_5678; bus_b.A1 = 5'd0;
    tick();
    bus_b.WE3 = 1'b0; bus_b.A1 = 5'd7;
    #1;
    chk("wr_x7_b", bus_b.RD1, 32'h1234_5678);
    chk("wr_x7_n", bus_n.RD1, 32'h1234_5678);

    // x0 stays zero, including through the bypass.
    bus_b.WE3 = 1'b1; bus_b.A3 = 5'd0; bus_b.WD3 = 32'hFFFF_FFFF; bus_b.A2 = 5'd0;
    #1;
    chk("x0_byp", bus_b.RD2, 32'd0);
    tick();
    bus_b.WE3 = 1'b0;
    #1;
    chk("x0_rd_b", bus_b.RD2, 32'd0);
    chk("x0_rd_n", bus_n.RD2, 32'd0);

    // Bypass versus stored value.
    bus_b.WE3 = 1'b1; bus_b.A3 = 5'd9; bus_b.WD3 = 32'h1111_1111;
    tick();
    bus_b.WD3 = 32'hA5A5_A5A5; bus_b.A1 = 5'd9;
    #1;
    chk("byp_on",  bus_b.RD1, 32'hA5A5_A5A5);
    chk("byp_off", bus_n.RD1, 32'h1111_1111);
    tick();
    bus_b.WE3 = 1'b0;
    #1;
    chk("byp_after_b", bus_b.RD1, 32'hA5A5_A5A5);
    chk("byp_after_n", bus_n.RD1, 32'hA5A5_A5A5);

    // Scoreboard set, then clear by writeback.
    bus_b.sb_set = 1'b1; bus_b.sb_addr = 5'd3; bus_b.A1 = 5'd3;
    #1;
    chk("sb_set_same", 32'(bus_b.busy1), 32'd0);
    tick();
    bus_b.sb_set = 1'b0;
    #1;
    chk("sb_set_b", 32'(bus_b.busy1), 32'd1);
    chk("sb_set_n", 32'(bus_n.busy1), 32'd1);
    bus_b.WE3 = 1'b1; bus_b.A3 = 5'd3; bus_b.WD3 = 32'h0000_0033;
    #1;
    chk("sb_clr_byp_b", 32'(bus_b.busy1), 32'd0);
    chk("sb_clr_byp_n", 32'(bus_n.busy1), 32'd1);
    tick();
    bus_b.WE3 = 1'b0;
    #1;
    chk("sb_clr_b", 32'(bus_b.busy1), 32'd0);
    chk("sb_clr_n", 32'(bus_n.busy1), 32'd0);

    // Setting x0 has no effect.
    bus_b.sb_set = 1'b1; bus_b.sb_addr = 5'd0; bus_b.A1 = 5'd0; bus_b.A2 = 5'd0;
    tick();
    bus_b.sb_set = 1'b0;
    #1;
    chk("sb_x0_b1", 32'(bus_b.busy1), 32'd0);
    chk("sb_x0_n2", 32'(bus_n.busy2), 32'd0);

    // Same-cycle set and clear on x4: set wins.
    bus_b.sb_set = 1'b1; bus_b.sb_addr = 5'd4;
    bus_b.WE3 = 1'b1; bus_b.A3 = 5'd4; bus_b.WD3 = 32'h0000_0044; bus_b.A2 = 5'd4;
    #1;
    chk("coll_same_b", 32'(bus_b.busy2), 32'd0);
    tick();
    bus_b.sb_set = 1'b0; bus_b.WE3 = 1'b0;
    #1;
    chk("coll_busy_b", 32'(bus_b.busy2), 32'd1);
    chk("coll_busy_n", 32'(bus_n.busy2), 32'd1);
    chk("coll_rd2",    bus_b.RD2,        32'h0000_0044);

    // Reset in the middle of RUN with x7 busy.
    bus_b.sb_set = 1'b1; bus_b.sb_addr = 5'd7; bus_b.A1 = 5'd7;
    tick();
    bus_b.sb_set = 1'b0;
    #1;
    chk("pre_rst_busy",  32'(bus_b.busy1), 32'd1);
    chk("pre_rst_ready", 32'(bus_b.ready), 32'd1);
    rst = 1'b0;
    #2;
    chk("mid_rst_ready", 32'(bus_b.ready), 32'd0);
    chk("mid_rst_busy",  32'(bus_b.busy1), 32'd0);
    chk("mid_rst_rd1",   bus_b.RD1,        32'd0);
    #3 rst = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("resweep_ready", 32'(bus_n.ready), (k == 32) ? 32'd1 : 32'd0);
    end
    #1;
    chk("resweep_x7",   bus_b.RD1,        32'd0);
    chk("resweep_busy", 32'(bus_b.busy1), 32'd0);
    chk("resweep_x4",   bus_b.RD2,        32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
